// File: rtl/pcie_tx.sv
// pcie_tx: transmit-side TLP formatter feeding the 64-bit AXI stream of the PCIe core.
// Arbitrates completions, DMA read requests and DMA writes (cpl > rd > wr) and emits
// each as a 3DW-header TLP. Payload DWs are byte-reversed to match the receive parser.
module pcie_tx (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] requester_id,
    input  logic        cpl_request,
    input  logic [31:0] cpl_dw2,
    input  logic [63:0] cpl_data,
    output logic        cpl_ack,
    input  logic        rd_request,
    input  logic [24:0] rd_address,
    input  logic [7:0]  rd_tag,
    output logic        rd_ack,
    input  logic        wr_request,
    input  logic [24:0] wr_address,
    input  logic [63:0] wr_data,
    output logic        wr_data_read,
    output logic        wr_ack,
    output logic        tvalid,
    input  logic        tready,
    output logic        tlast,
    output logic [7:0]  tkeep,
    output logic [63:0] tdata
);

    // State names the beat currently presented on the stream.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CPL0,
        S_CPL1,
        S_CPL2,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_WRD,
        S_WRL
    } state_t;

    state_t      state_q, state_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic [63:0] tdata_q, tdata_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [24:0] addr_q, addr_d;
    logic [63:0] cdata_q, cdata_d;
    logic        pop;
    logic        load;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // The beat register may be refilled when empty or when its beat is being taken.
    assign load = !tvalid_q || tready;

    // Next-beat computation: each accepted beat loads the following one of the TLP.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tkeep_d  = tkeep_q;
        tdata_d  = tdata_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cdata_d  = cdata_q;
        pop      = 1'b0;
        if (load) begin
            case (state_q)
                S_IDLE: begin
                    if (cpl_request) begin
                        state_d  = S_CPL0;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tkeep_d  = 8'hFF;
                        tdata_d  = {requester_id, 16'h0008, 32'h4A00_0002};
                        cdata_d  = cpl_data;
                    end else if (rd_request) begin
                        state_d  = S_RD0;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tkeep_d  = 8'hFF;
                        tdata_d  = {requester_id, rd_tag, 8'hFF, 32'h0000_0020};
                        addr_d   = rd_address;
                    end else if (wr_request) begin
                        state_d  = S_WR0;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tkeep_d  = 8'hFF;
                        tdata_d  = {requester_id, 16'h00FF, 32'h4000_0020};
                        addr_d   = wr_address;
                    end
                end
                S_CPL0: begin
                    state_d = S_CPL1;
                    tdata_d = {swap32(cdata_q[31:0]), cpl_dw2};
                end
                S_CPL1: begin
                    state_d = S_CPL2;
                    tdata_d = {32'h0, swap32(cdata_q[63:32])};
                    tkeep_d = 8'h0F;
                    tlast_d = 1'b1;
                end
                S_RD0: begin
                    state_d = S_RD1;
                    tdata_d = {32'h0, addr_q, 7'd0};
                    tkeep_d = 8'h0F;
                    tlast_d = 1'b1;
                end
                S_WR0: begin
                    state_d = S_WR1;
                    tdata_d = {swap32(wr_data[31:0]), addr_q, 7'd0};
                    hold_d  = wr_data[63:32];
                    pop     = 1'b1;
                end
                S_WR1: begin
                    state_d = S_WRD;
                    cnt_d   = 4'd1;
                    tdata_d = {swap32(wr_data[31:0]), swap32(hold_q)};
                    hold_d  = wr_data[63:32];
                    pop     = 1'b1;
                end
                // Payload straddles qwords by one DW: the held high DW goes out
                // first, followed by the low DW of the qword just popped.
                S_WRD: begin
                    if (cnt_q == 4'd15) begin
                        state_d = S_WRL;
                        tdata_d = {32'h0, swap32(hold_q)};
                        tkeep_d = 8'h0F;
                        tlast_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        tdata_d = {swap32(wr_data[31:0]), swap32(hold_q)};
                        hold_d  = wr_data[63:32];
                        pop     = 1'b1;
                    end
                end
                S_CPL2, S_RD1, S_WRL: begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tkeep_d  = 8'h00;
                end
                default: begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tkeep_d  = 8'h00;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
            tdata_q  <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            cdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tkeep_q  <= tkeep_d;
            tdata_q  <= tdata_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cdata_q  <= cdata_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tkeep  = tkeep_q;
    assign tdata  = tdata_q;

    // Acks mark acceptance of the tlast beat; the last-beat states always have tvalid set.
    assign cpl_ack      = (state_q == S_CPL2) && tready && !reset;
    assign rd_ack       = (state_q == S_RD1) && tready && !reset;
    assign wr_ack       = (state_q == S_WRL) && tready && !reset;
    assign wr_data_read = pop && !reset;

endmodule
